// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Single-cycle ALU with valid/ready handshake and a serial
//               shift-add multiplier that takes WIDTH cycles per product.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [2:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

  localparam logic [2:0] c_op_fwd = 3'b000;
  localparam logic [2:0] c_op_add = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_or  = 3'b011;
  localparam logic [2:0] c_op_sub = 3'b100;
  localparam logic [2:0] c_op_xor = 3'b101;
  localparam logic [2:0] c_op_mul = 3'b110;
  localparam logic [2:0] c_op_sll = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic               w_sll_oor;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_carry;
  logic [2*WIDTH-1:0] w_acc_step;
  logic               w_accept;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign busy      = (state_q == S_MUL);
  assign w_accept  = in_valid && in_ready;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;

  assign w_sum      = {1'b0, data1} + {1'b0, data2};
  assign w_diff     = {1'b0, data1} - {1'b0, data2};
  // Any bit of B at or above log2(WIDTH) means the shift is >= WIDTH
  assign w_sll_oor  = |(data2 >> CW);
  assign w_acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (select)
      c_op_fwd: w_alu_res = data2;
      c_op_add: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      c_op_and: w_alu_res = data1 & data2;
      c_op_or:  w_alu_res = data1 | data2;
      c_op_sub: begin
        w_alu_res   = w_diff[WIDTH-1:0];
        w_alu_carry = w_diff[WIDTH];
      end
      c_op_xor: w_alu_res = data1 ^ data2;
      c_op_sll: w_alu_res = w_sll_oor ? '0 : (data1 << data2[CW-1:0]);
      default:  w_alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (select == c_op_mul) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, data1};
            mplier_d = data2;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d    = w_alu_res;
            carry_d     = w_alu_carry;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = w_acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == c_cnt_last) begin
          result_d    = w_acc_step[WIDTH-1:0];
          carry_d     = |w_acc_step[2*WIDTH-1:WIDTH];
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flag tracks whatever value lands in the result register
    zero_d = (result_d == '0);
    if (result_d == result_q && out_valid_d == out_valid_q && state_d == state_q
        && !(w_accept && select != c_op_mul)) begin
      zero_d = zero_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Directed-vector bench for alu_pipe with a queue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

  localparam int WIDTH = 8;

  localparam logic [2:0] c_fwd = 3'b000;
  localparam logic [2:0] c_add = 3'b001;
  localparam logic [2:0] c_and = 3'b010;
  localparam logic [2:0] c_or  = 3'b011;
  localparam logic [2:0] c_sub = 3'b100;
  localparam logic [2:0] c_xor = 3'b101;
  localparam logic [2:0] c_mul = 3'b110;
  localparam logic [2:0] c_sll = 3'b111;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [2:0]       select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] mon_exp;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .data1    (data1),
    .data2    (data2),
    .select   (select),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Presents an op, waits (bounded) for acceptance, returns at the next negedge
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic ez, input logic ec,
                      input bit push, output int waited);
    select   = op;
    data1    = a;
    data2    = b;
    in_valid = 1'b1;
    waited   = 0;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op=%b not accepted within %0d cycles", op, waited);
    end else if (push) begin
      exp_q.push_back({er, ez, ec});
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    #1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, out_valid, 1);
    @(negedge clk);
  endtask

  // Monitor: pops and compares on every output handshake
  always @(negedge clk) begin
    #2;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got result=%h zero=%b carry=%b with nothing expected",
                 result, zero, carry);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({result, zero, carry} !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard: got result=%h zero=%b carry=%b want result=%h zero=%b carry=%b",
                   result, zero, carry, mon_exp[WIDTH+1:2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit seen;
    reset = 1'b1; in_valid = 1'b0; data1 = '0; data2 = '0; select = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    // Op on the reset edge must be dropped
    in_valid = 1'b1; select = c_add; data1 = 8'h01; data2 = 8'h02;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    send(c_add, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1, w);
    #1 chk("add_out_valid", out_valid, 1);
    @(negedge clk);
    #1 chk("add_one_cycle", out_valid, 0);
    @(negedge clk);
    send(c_add, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b1, w);

    send(c_sub, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b1, w);
    send(c_xor, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b1, w);
    chk("xor_back_to_back_wait", w, 0);
    send(c_sub, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1, w);
    @(negedge clk);

    send(c_mul, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b1, w);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("mul_busy", busy, 1);
      chk("mul_in_ready_low", in_ready, 0);
      chk("mul_no_early_valid", out_valid, 0);
      @(negedge clk);
    end
    #1;
    chk("mul_valid_at_8", out_valid, 1);
    chk("mul_busy_clear", busy, 0);
    @(negedge clk);

    send(c_mul, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b1, w);
    wait_out("mul2_timeout");
    send(c_mul, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, w);
    wait_out("mul3_timeout");
    send(c_mul, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b1, w);
    wait_out("mul4_timeout");

    // Backpressure: AND result held while an OR waits
    out_ready = 1'b0;
    send(c_and, 8'hD5, 8'hEA, 8'hC0, 1'b0, 1'b0, 1'b1, w);
    select = c_or; data1 = 8'h01; data2 = 8'h02; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_result", result, 8'hC0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(c_or, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b1, w);
    chk("or_accept_on_release", w, 0);
    #1 chk("or_result", result, 8'h03);
    @(negedge clk);

    // Reset in the 4th MUL cycle aborts the product
    send(c_mul, 8'h0F, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, w);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", seen, 0);
    @(negedge clk);
    send(c_fwd, 8'h33, 8'h7E, 8'h7E, 1'b0, 1'b0, 1'b1, w);

    send(c_sll, 8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, w);
    send(c_sll, 8'h81, 8'h08, 8'h00, 1'b1, 1'b0, 1'b1, w);
    send(c_sll, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b1, w);

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
